store_drain_responder: RTL
==========================

# store_drain_responder

Memory-side responder for the store buffer drain interface. It accepts one byte-masked word write per valid/ready handshake and commits it to a word-addressed data RAM after a configurable write latency. It also serves a one-cycle-latency load read port. It sits between the store buffer's `mem_*` outputs and the data memory array, replacing the idealised always-ready memory model used in simulation so far.

## Interface
- `ADDR_WIDTH`, 10: word-index width; RAM holds 2^ADDR_WIDTH 32-bit words.
- `WRITE_LAT`, 2: cycles spent in BUSY before acknowledging; legal range 0..15.
- `clk` in 1: sole clock; all state changes on rising edge.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `mem_valid` in 1: drain request present; held with stable payload until `mem_ready`.
- `mem_addr` in 32: byte address; bits [1:0] ignored.
- `mem_data` in 32: write data, byte lanes aligned to the word.
- `mem_byte_en` in 4: lane enables, bit k selects `mem_data[8k+7:8k]`.
- `mem_ready` out 1: high for exactly one cycle per accepted request; transfer completes on that edge.
- `rd_en` in 1: load read request.
- `rd_addr` in 32: load byte address; bits [1:0] ignored.
- `rd_data` out 32: registered read data.
- `rd_valid` out 1: `rd_en` delayed one cycle.
- `oob_err` out 1: sticky; set when any write or read address has nonzero bits above `[ADDR_WIDTH+1:2]`.
- `wr_count` out 32: completed write handshakes; wraps modulo 2^32.

## Operation
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - If `mem_valid`=1, capture addr, data and byte_en into holding registers.
  - Go to BUSY with latency counter = `WRITE_LAT`-1, or go directly to ACK if `WRITE_LAT`=0.
  - If `mem_valid`=0, stay in IDLE.
- BUSY: decrement the counter. Go to ACK on the cycle the counter is 0.
- ACK:
  - `mem_ready`=1, decoded from the state register with no combinational path from inputs.
  - At the closing edge: write the captured enabled lanes into RAM word `addr[ADDR_WIDTH+1:2]`, increment `wr_count`, go to IDLE.
- Writes are committed at capture:
  - If `mem_valid` drops during BUSY (protocol violation), the captured write still completes and `mem_ready` still pulses.
  - Payload changes after capture are ignored.
- `mem_byte_en`=0000: the full handshake still occurs and `wr_count` increments; the RAM word is unchanged.
- Out-of-range address: the index aliases (upper bits dropped) and `oob_err` sets. It clears only on reset.
- Reads: when `rd_en`=1, `rd_data` is loaded with RAM word `rd_addr[ADDR_WIDTH+1:2]` at the next edge and `rd_valid`=1. When `rd_en`=0, `rd_data` holds its value.
- Read/commit collision on the same word in the same cycle: `rd_data` returns the pre-write contents (read-before-write).

## Timing
- Reset values: state IDLE; `mem_ready` 0, `rd_valid` 0, `rd_data` 0, `oob_err` 0, `wr_count` 0; holding registers 0. RAM contents are not reset.
- Reset asserted mid-transaction aborts it: nothing is written and no `mem_ready` is issued. The requester re-presents the request after reset.
- Request latency: `mem_valid` first seen high at edge t gives `mem_ready` high during cycle t+1+`WRITE_LAT`.
- Minimum spacing is `WRITE_LAT`+2 cycles per write. IDLE samples the next request on the cycle after ACK.
- Read latency is 1 cycle. Reads are accepted in every cycle and every state and never stall.

## Structure
- Shared package `dmem_pkg`: FSM state enum (IDLE/BUSY/ACK), `WORD_W`=32, `BE_W`=4, and a function mapping a byte address to a word index.
- Sub-module `dmem_bram`: 2^ADDR_WIDTH x 32 RAM with one byte-enabled synchronous write port and one synchronous read-before-write read port.
- Top level holds the FSM, latency counter, holding registers, `wr_count` and `oob_err`.

## Test plan
- Reset, then one write with `WRITE_LAT`=2: addr 0x10, data 0xDEADBEEF, be 1111 -> `mem_ready` is a single-cycle pulse 3 cycles after `mem_valid` rises; read of 0x10 returns 0xDEADBEEF; `wr_count`=1.
- Partial writes to 0x20: 0x11223344 with be 1111, then 0xAABBCCDD with be 0101 -> read returns 0x11BB33DD.
- Back-to-back valid held high for 4 requests with `WRITE_LAT`=0 -> `mem_ready` pulses every 2 cycles; `wr_count`=4; all 4 words correct.
- Read of 0x30 in the ACK cycle of a write of 0x55555555 to 0x30 (old value 0) -> `rd_data`=0; a read the next cycle returns 0x55555555.
- Write to addr 0x00001004 with `ADDR_WIDTH`=10 -> `oob_err`=1; word index 1 is updated; `oob_err` stays set until `reset_n` is pulsed.
- `reset_n` asserted low during BUSY -> `mem_ready` never pulses, the target word is unchanged, `wr_count`=0, and the FSM accepts a new request right after reset release.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the store drain responder and its RAM.
// FSM state enum, word/lane widths, byte-address to word-index helper.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Full-width result so callers can both slice the index
  // and test the bits above it for out-of-range addresses.
  function automatic logic [31:0] word_idx(
    input logic [31:0] byte_addr
  );
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// dmem_bram: 2^ADDR_WIDTH x 32 RAM, byte-enabled sync write port,
// sync read-before-write read port; ports we/waddr/wdata/wbe, re/raddr/rdata.
module dmem_bram
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [BE_W-1:0]       wbe,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WORD_W-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_d;
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (wbe[k]) begin
          mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

  // Sampling the array before the edge gives old data
  // when a read and a write hit the same word together.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/store_drain_responder.sv
// store_drain_responder: valid/ready drain write port with latency FSM,
// 1-cycle load read port, sticky oob_err and wr_count over a dmem_bram.
module store_drain_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WRITE_LAT  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [WORD_W-1:0] mem_data,
  input  logic [BE_W-1:0]   mem_byte_en,
  output logic              mem_ready,
  input  logic              rd_en,
  input  logic [31:0]       rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              oob_err,
  output logic [31:0]       wr_count
);

  localparam logic [3:0] LAT_INIT =
    (WRITE_LAT == 0) ? 4'd0 : 4'(WRITE_LAT - 1);

  logic [31:0] wr_idx;
  logic [31:0] rd_idx;
  logic        wr_oob;
  logic        rd_oob;

  state_e                state_q;
  state_e                state_d;
  logic [3:0]            cnt_q;
  logic [3:0]            cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [WORD_W-1:0]     data_q;
  logic [WORD_W-1:0]     data_d;
  logic [BE_W-1:0]       be_q;
  logic [BE_W-1:0]       be_d;
  logic [31:0]           wr_count_q;
  logic [31:0]           wr_count_d;
  logic                  oob_q;
  logic                  oob_d;
  logic                  rd_valid_q;
  logic                  rd_valid_d;
  logic                  ram_we;

  assign wr_idx = word_idx(mem_addr);
  assign rd_idx = word_idx(rd_addr);
  assign wr_oob = |(wr_idx >> ADDR_WIDTH);
  assign rd_oob = |(rd_idx >> ADDR_WIDTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      be_q       <= '0;
      wr_count_q <= '0;
      oob_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      be_q       <= be_d;
      wr_count_q <= wr_count_d;
      oob_q      <= oob_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Payload is latched on acceptance; later input changes
  // or a dropped valid cannot alter the pending write.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    be_d       = be_q;
    wr_count_d = wr_count_q;
    oob_d      = oob_q | (rd_en & rd_oob);
    rd_valid_d = rd_en;
    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d = wr_idx[ADDR_WIDTH-1:0];
          data_d = mem_data;
          be_d   = mem_byte_en;
          oob_d  = oob_d | wr_oob;
          cnt_d  = LAT_INIT;
          if (WRITE_LAT == 0) begin
            state_d = ACK;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        wr_count_d = wr_count_q + 32'd1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ready comes straight off the state register.
  always_comb begin
    mem_ready = (state_q == ACK);
    ram_we    = (state_q == ACK);
  end

  dmem_bram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we),
    .waddr   (addr_q),
    .wdata   (data_q),
    .wbe     (be_q),
    .re      (rd_en),
    .raddr   (rd_idx[ADDR_WIDTH-1:0]),
    .rdata   (rd_data)
  );

  assign rd_valid = rd_valid_q;
  assign oob_err  = oob_q;
  assign wr_count = wr_count_q;

endmodule
